// File: rtl/matrix_stream_pkg.sv
// Shared definitions for the matrix result streamer: FSM encoding and width/offset helpers.
package matrix_stream_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Index widths never collapse to zero bits, even for a single row or column.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int elem_offset(input int row, input int col, input int width, input int dw);
    return (row * width + col) * dw;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column walker with wrap and clear; MATRIX_STREAM_COL_MAJOR_EN selects column-major order.
module matrix_index_counter
  import matrix_stream_pkg::*;
#(
  parameter int  MATRIX_HEIGHT = 2,
  parameter int  MATRIX_WIDTH  = 2,
  localparam int ROW_W         = clog2_min1(MATRIX_HEIGHT),
  localparam int COL_W         = clog2_min1(MATRIX_WIDTH)
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             row_end;
  logic             col_end;

  assign row_end = (row_q == ROW_W'(MATRIX_HEIGHT - 1));
  assign col_end = (col_q == COL_W'(MATRIX_WIDTH - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
`ifdef MATRIX_STREAM_COL_MAJOR_EN
      if (row_end) begin
        row_d = '0;
        col_d = col_end ? '0 : col_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
`else
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = row_end && col_end;

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a flattened matrix on a load edge and streams it one element per valid/accept handshake.
// Define MATRIX_STREAM_COL_MAJOR_EN for column-major emission order.
module matrix_result_streamer
  import matrix_stream_pkg::*;
#(
  parameter int  MATRIX_HEIGHT = 2,
  parameter int  MATRIX_WIDTH  = 2,
  parameter int  DATA_WIDTH    = 8,
  localparam int ROW_W         = clog2_min1(MATRIX_HEIGHT),
  localparam int COL_W         = clog2_min1(MATRIX_WIDTH),
  localparam int MATRIX_SIZE   = MATRIX_HEIGHT * MATRIX_WIDTH * DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic [MATRIX_SIZE-1:0] i_matrix,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [ROW_W-1:0]       o_row,
  output logic [COL_W-1:0]       o_col,
  output logic                   o_valid,
  input  logic                   i_accept,
  output logic                   o_last,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overrun
);

  logic [0:0]             state_q, state_d;
  logic [MATRIX_SIZE-1:0] buf_q, buf_d;
  logic                   load_q;
  logic                   done_q, done_d;
  logic                   ovr_q, ovr_d;

  logic                   load_evt;
  logic                   streaming;
  logic                   transfer;
  logic                   final_xfer;
  logic                   capture;
  logic                   idx_last;
  logic [ROW_W-1:0]       row;
  logic [COL_W-1:0]       col;
  logic [DATA_WIDTH-1:0]  elem [MATRIX_HEIGHT][MATRIX_WIDTH];

  assign load_evt   = i_load && !load_q;
  assign streaming  = (state_q == ST_STREAM);
  assign transfer   = streaming && i_accept;
  assign final_xfer = transfer && idx_last;
  // A load edge landing on the final transfer chains straight into the next matrix.
  assign capture    = load_evt && (!streaming || final_xfer);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    ovr_d   = ovr_q;
    done_d  = final_xfer;
    if (capture) begin
      state_d = ST_STREAM;
      buf_d   = i_matrix;
      ovr_d   = 1'b0;
    end else begin
      if (final_xfer) state_d = ST_IDLE;
      if (load_evt)   ovr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      load_q  <= i_load;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  matrix_index_counter #(
    .MATRIX_HEIGHT(MATRIX_HEIGHT),
    .MATRIX_WIDTH (MATRIX_WIDTH)
  ) u_index (
    .clk      (clk),
    .rst_ni   (i_rst_n),
    .clear_i  (capture),
    .advance_i(transfer),
    .row_o    (row),
    .col_o    (col),
    .last_o   (idx_last)
  );

  for (genvar gi = 0; gi < MATRIX_HEIGHT; gi++) begin : g_row
    for (genvar gj = 0; gj < MATRIX_WIDTH; gj++) begin : g_col
      assign elem[gi][gj] = buf_q[elem_offset(gi, gj, MATRIX_WIDTH, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  assign o_data    = elem[row][col];
  assign o_row     = row;
  assign o_col     = col;
  assign o_valid   = streaming;
  assign o_busy    = streaming;
  assign o_last    = streaming && idx_last;
  assign o_done    = done_q;
  assign o_overrun = ovr_q;

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Reader end of the flattened-matrix result interface (`o_result`/`o_ready`) of the matrix multiplier.
- Detects a load strobe, captures the whole flattened matrix into an internal buffer, then emits one element per handshake in row-major order.
- Each element carries row/col indices and a last flag on a valid/accept stream.
- Sits between the multiplier and any element-serial consumer (UART formatter, memory writer, next pipeline stage).

Parameters:
- MATRIX_HEIGHT, 2, number of rows of the captured matrix
- MATRIX_WIDTH, 2, number of columns of the captured matrix
- DATA_WIDTH, 8, bits per element
- (derived) ROW_W = max(1, clog2(MATRIX_HEIGHT)), COL_W = max(1, clog2(MATRIX_WIDTH)), MATRIX_SIZE = MATRIX_HEIGHT*MATRIX_WIDTH*DATA_WIDTH

Ports:
- clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_load  in  1  load strobe, driven from the multiplier's `o_ready`; rising-edge detected internally, so a level or a pulse both work
- i_matrix  in  MATRIX_SIZE  flattened matrix; element (r,c) is at bits [(r*MATRIX_WIDTH+c)*DATA_WIDTH +: DATA_WIDTH]
- o_data  out  DATA_WIDTH  current element
- o_row  out  ROW_W  row index of o_data
- o_col  out  COL_W  column index of o_data
- o_valid  out  1  o_data/o_row/o_col/o_last are valid
- i_accept  in  1  downstream ready; a transfer occurs when o_valid && i_accept
- o_last  out  1  current element is the final one of the matrix
- o_busy  out  1  streaming in progress
- o_done  out  1  one-cycle pulse after the final transfer
- o_overrun  out  1  sticky flag: a load edge arrived while busy and was dropped

Behaviour:
- Reset (async, i_rst_n=0): state IDLE.
  - All outputs 0, buffer 0, counters 0.
  - Load-edge history register cleared to 0, so i_load held high at reset release counts as a rising edge.
- Edge detect: load_evt = i_load && !i_load_q. i_load_q is registered every cycle.
- State IDLE:
  - On load_evt at edge N: i_matrix is captured into the buffer, counters are set to (0,0), state goes to STREAM.
  - o_valid=1 and o_busy=1 from edge N; o_data = element (0,0) in the cycle after N. Latency from the sampled strobe to the first valid is 1 cycle.
- State STREAM:
  - o_valid stays 1.
  - o_data, o_row, o_col are stable while !i_accept; no element is dropped or repeated.
  - On a transfer, the counter advances: col increments; at col==MATRIX_WIDTH-1, col wraps to 0 and row increments.
  - o_last = (row==MATRIX_HEIGHT-1 && col==MATRIX_WIDTH-1).
  - On a transfer with o_last=1, state returns to IDLE: o_valid and o_busy drop, and o_done=1 for exactly one cycle.
- Simultaneous load_evt and final transfer:
  - The new matrix is captured and state stays STREAM, with counters at (0,0).
  - o_done still pulses and o_valid stays high (back-to-back matrices, no bubble).
- load_evt in STREAM that is not coincident with the final transfer:
  - The event is ignored and the buffer is unchanged.
  - o_overrun is set; it is cleared only by reset or by the next load_evt that is captured.
- i_matrix is sampled only on capture; later changes to it have no effect.
- 1x1 matrix: o_last=1 on the first element, and a single transfer completes the matrix.
- Element extraction from the buffer is a combinational mux on the counters; the outputs are driven from registered counters and the buffer, so no input-to-output combinational path exists except through i_accept into the next-state logic.

Optional Feature:
- Macro: MATRIX_STREAM_COL_MAJOR_EN.
- Defined: emission order is column-major. Row increments first; at row==MATRIX_HEIGHT-1 row wraps to 0 and col increments. o_last is the same condition, o_row/o_col still report the true indices, and all handshake and timing rules are unchanged.
- Undefined: row-major order as above.

Decomposition:
- Package matrix_stream_pkg:
  - state encoding (IDLE, STREAM)
  - clog2-with-minimum-1 width function
  - element bit-offset helper function
- One natural sub-module, matrix_index_counter: a row/col counter with wrap, an advance enable, a synchronous load-to-zero, an o_last output, and the order selected by MATRIX_STREAM_COL_MAJOR_EN.

Test Plan:
- Basic, 2x2, i_matrix = {8'd1,8'd2,8'd3,8'd4}, i_accept=1, single load pulse -> o_data sequence 4,3,2,1 on four consecutive cycles; (row,col) = (0,0),(0,1),(1,0),(1,1); o_last only on value 1; o_done one cycle later; o_busy=0 afterwards.
- Backpressure: same matrix, i_accept toggled 1,0,0,1,0,1,1 -> every value held while i_accept=0; exactly 4 transfers, values 4,3,2,1, no duplicates.
- Level strobe: i_load held high for 20 cycles -> exactly one matrix streamed, o_overrun stays 0.
- Overrun: second i_load pulse during the second transfer with i_matrix={8'd9,8'd9,8'd9,8'd9} -> output stays 4,3,2,1 and o_overrun=1; a next load in IDLE clears o_overrun and streams 9,9,9,9.
- Back-to-back and reset:
  - A load edge coincident with the final transfer -> o_valid never drops; next data = element 0 of the new matrix.
  - Asserting i_rst_n=0 mid-stream -> all outputs 0 immediately, and a fresh load restarts at (0,0).
- With MATRIX_STREAM_COL_MAJOR_EN defined, 2x2 {1,2,3,4} -> sequence 4,2,3,1; (row,col) = (0,0),(1,0),(0,1),(1,1).
